// File: rtl/glitc_trigger_multi.sv
// N-channel power-sum trigger: neighbour phi sums plus optional external GLITC power,
// per-channel threshold/mask/enable, retrigger holdoff and saturating scalers.
module glitc_trigger_multi #(
    parameter int NCHAN       = 4,
    parameter int POWERBITS   = 12,
    parameter int SCALERBITS  = 24,
    parameter int HOLDOFFBITS = 8,
    parameter int ADDRBITS    = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NCHAN*POWERBITS-1:0] phi_power_i,
    input  logic [NCHAN*POWERBITS-1:0] ext_power_i,
    input  logic [NCHAN-1:0]           ext_valid_i,
    output logic [NCHAN-1:0]           trigger_o,
    input  logic                       hsk_update_i,
    input  logic                       user_sel_i,
    input  logic                       user_wr_i,
    input  logic [ADDRBITS-1:0]        user_addr_i,
    input  logic [31:0]                user_dat_i,
    output logic [31:0]                user_dat_o
);

    localparam int SW = POWERBITS + 2;

    function automatic logic [SCALERBITS-1:0] sat_inc(input logic [SCALERBITS-1:0] v);
        return (&v) ? v : v + SCALERBITS'(1);
    endfunction

    logic [NCHAN-1:0][SW-1:0]          thresh_r;
    logic [NCHAN-1:0]                  mask_r;
    logic [NCHAN-1:0]                  en_r;
    logic [HOLDOFFBITS-1:0]            holdoff_r;

    logic [NCHAN*POWERBITS-1:0]        phi_p0;
    logic [NCHAN*POWERBITS-1:0]        ext_p0;
    logic [NCHAN-1:0]                  evld_p0;

    logic [NCHAN-1:0][SW-1:0]          sum_nx_c;
    logic [NCHAN-1:0][SW-1:0]          sum_ex_c;
    logic [NCHAN-1:0][SW-1:0]          sum_nx_p1;
    logic [NCHAN-1:0][SW-1:0]          sum_ex_p1;

    logic [NCHAN-1:0][SW-1:0]          sum_sel;
    logic [NCHAN-1:0]                  fire;
    logic [NCHAN-1:0]                  trig_nx;
    logic [NCHAN-1:0]                  trig_p2;
    logic [NCHAN-1:0][HOLDOFFBITS-1:0] hc;

    logic [NCHAN-1:0][SCALERBITS-1:0]  cnt;
    logic [NCHAN-1:0][SCALERBITS-1:0]  scaler;

    logic                              reg_wr;
    logic [31:0]                       rd_dat;
    logic                              unused_dat;

    assign reg_wr     = user_sel_i && user_wr_i;
    assign unused_dat = ^user_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NCHAN; n++) thresh_r[n] <= '1;
            mask_r    <= '1;
            en_r      <= '0;
            holdoff_r <= '0;
        end else if (reg_wr) begin
            for (int n = 0; n < NCHAN; n++) begin
                if (user_addr_i == ADDRBITS'(n)) begin
                    thresh_r[n] <= user_dat_i[SW-1:0];
                    mask_r[n]   <= user_dat_i[16];
                    en_r[n]     <= user_dat_i[17];
                end
            end
            if (user_addr_i == ADDRBITS'(2*NCHAN))
                holdoff_r <= user_dat_i[HOLDOFFBITS-1:0];
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int n = 0; n < NCHAN; n++) begin
            if (user_addr_i == ADDRBITS'(n)) begin
                rd_dat[SW-1:0] = thresh_r[n];
                rd_dat[16]     = mask_r[n];
                rd_dat[17]     = en_r[n];
            end
            if (user_addr_i == ADDRBITS'(NCHAN + n))
                rd_dat = 32'(scaler[n]);
        end
        if (user_addr_i == ADDRBITS'(2*NCHAN))
            rd_dat = 32'(holdoff_r);
    end

    assign user_dat_o = rd_dat;

    // Stage 0: input capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phi_p0  <= '0;
            ext_p0  <= '0;
            evld_p0 <= '0;
        end else begin
            phi_p0  <= phi_power_i;
            ext_p0  <= ext_power_i;
            evld_p0 <= ext_valid_i;
        end
    end

    // Both the unmasked and masked sums are carried so that the mask is applied
    // together with threshold and enable at the compare, keeping register updates atomic.
    always_comb begin
        for (int n = 0; n < NCHAN; n++) begin
            sum_nx_c[n] = SW'(phi_p0[n*POWERBITS +: POWERBITS])
                        + SW'(phi_p0[((n+1) % NCHAN)*POWERBITS +: POWERBITS]);
            sum_ex_c[n] = sum_nx_c[n]
                        + (evld_p0[n] ? SW'(ext_p0[n*POWERBITS +: POWERBITS]) : SW'(0));
        end
    end

    // Stage 1: sums
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_nx_p1 <= '0;
            sum_ex_p1 <= '0;
        end else begin
            sum_nx_p1 <= sum_nx_c;
            sum_ex_p1 <= sum_ex_c;
        end
    end

    always_comb begin
        for (int n = 0; n < NCHAN; n++) begin
            sum_sel[n] = mask_r[n] ? sum_nx_p1[n] : sum_ex_p1[n];
            fire[n]    = en_r[n] && (sum_sel[n] > thresh_r[n]);
            trig_nx[n] = fire[n] && (hc[n] == '0);
        end
    end

    // Stage 2: compare, holdoff and trigger output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_p2 <= '0;
            hc      <= '0;
        end else begin
            trig_p2 <= trig_nx;
            for (int n = 0; n < NCHAN; n++) begin
                if (trig_nx[n])
                    hc[n] <= holdoff_r;
                else if (hc[n] != '0)
                    hc[n] <= hc[n] - HOLDOFFBITS'(1);
            end
        end
    end

    assign trigger_o = trig_p2;

    // A trigger coincident with the latch strobe is counted in the new period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            scaler <= '0;
        end else begin
            for (int n = 0; n < NCHAN; n++) begin
                if (hsk_update_i) begin
                    scaler[n] <= cnt[n];
                    cnt[n]    <= SCALERBITS'(trig_p2[n]);
                end else if (trig_p2[n]) begin
                    cnt[n]    <= sat_inc(cnt[n]);
                end
            end
        end
    end

endmodule

// File: tb/tb_glitc_trigger_multi.sv
// Directed bench for glitc_trigger_multi: threshold edge, external power masking,
// holdoff spacing, scaler latch/saturation, register map and mid-run reset.
module tb_glitc_trigger_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] phi;
    logic [47:0] ext;
    logic [3:0]  ev;
    logic [3:0]  trig;
    logic [3:0]  trig_sat;
    logic        hsk;
    logic        sel;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [31:0] rdat_sat;
    logic [31:0] tmp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    glitc_trigger_multi u_dut (
        .clk_i(clk), .rst_i(rst), .phi_power_i(phi), .ext_power_i(ext), .ext_valid_i(ev),
        .trigger_o(trig), .hsk_update_i(hsk), .user_sel_i(sel), .user_wr_i(wr),
        .user_addr_i(addr), .user_dat_i(wdat), .user_dat_o(rdat)
    );

    glitc_trigger_multi #(.SCALERBITS(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .phi_power_i(phi), .ext_power_i(ext), .ext_valid_i(ev),
        .trigger_o(trig_sat), .hsk_update_i(hsk), .user_sel_i(sel), .user_wr_i(wr),
        .user_addr_i(addr), .user_dat_i(wdat), .user_dat_o(rdat_sat)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
        sel  = 1'b1;
        wr   = 1'b1;
        addr = a;
        wdat = d;
        tick();
        sel  = 1'b0;
        wr   = 1'b0;
    endtask

    task automatic reg_rd(input logic [5:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdat;
    endtask

    task automatic hsk_pulse();
        hsk = 1'b1;
        tick();
        hsk = 1'b0;
    endtask

    initial begin
        rst = 1'b1; phi = '0; ext = '0; ev = '0; hsk = 1'b0;
        sel = 1'b0; wr = 1'b0; addr = '0; wdat = '0;
        tick(2);
        check("rst_trig", 32'(trig), 32'h0);
        reg_rd(6'd0, tmp); check("rst_thresh0", tmp, 32'h0001_3FFF);
        reg_rd(6'd8, tmp); check("rst_holdoff", tmp, 32'h0);
        reg_rd(6'd4, tmp); check("rst_scaler0", tmp, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_trig", 32'(trig), 32'h0);
        end

        // equal-to-threshold does not fire; one more LSB does, 3 cycles later
        reg_wr(6'd0, 32'h0003_0064);
        phi[0 +: 12] = 12'd50;
        phi[12 +: 12] = 12'd50;
        ext = {4{12'hFFF}};
        ev = 4'hF;
        tick(4);
        check("t1_equal", 32'(trig[0]), 32'h0);
        phi[12 +: 12] = 12'd51;
        tick(); check("t1_lat1", 32'(trig[0]), 32'h0);
        tick(); check("t1_lat2", 32'(trig[0]), 32'h0);
        tick(); check("t1_lat3", 32'(trig[0]), 32'h1);
        phi[12 +: 12] = 12'd50;
        tick(3);
        check("t1_drop", 32'(trig[0]), 32'h0);
        reg_wr(6'd0, 32'h0001_0064);

        // external power enters the sum only when valid and unmasked
        phi[24 +: 12] = 12'hFFF;
        phi[36 +: 12] = 12'hFFF;
        ev = 4'b0100;
        reg_wr(6'd2, 32'h0002_3FFF);
        tick(3);
        check("t2_sum12285_vs_max", 32'(trig[2]), 32'h0);
        reg_wr(6'd2, 32'h0002_2FFC);
        tick();
        check("t2_thr12284", 32'(trig[2]), 32'h1);
        ev = 4'b0000;
        tick(2);
        check("t2_ev0_lat", 32'(trig[2]), 32'h1);
        tick();
        check("t2_ev0", 32'(trig[2]), 32'h0);
        ev = 4'b0100;
        tick(3);
        check("t2_ev1", 32'(trig[2]), 32'h1);
        reg_wr(6'd2, 32'h0003_2FFC);
        tick();
        check("t2_masked", 32'(trig[2]), 32'h0);
        reg_wr(6'd2, 32'h0001_3FFF);
        phi[24 +: 12] = 12'd0;
        phi[36 +: 12] = 12'd0;
        ev = 4'b0000;

        // holdoff 5 spaces pulses 6 cycles apart
        reg_wr(6'd8, 32'd5);
        reg_wr(6'd1, 32'h0003_000A);
        begin
            int waited = 0;
            while (trig[1] !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            check("t3_first_pulse", 32'(trig[1]), 32'h1);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            check($sformatf("t3_period_k%0d", k), 32'(trig[1]), (k % 6 == 0) ? 32'h1 : 32'h0);
        end
        reg_wr(6'd8, 32'd0);
        tick(8);
        for (int k = 0; k < 4; k++) begin
            check("t3_level", 32'(trig[1]), 32'h1);
            tick();
        end

        // scalers: 10 pulses, coincident pulse, saturation
        reg_wr(6'd1, 32'h0001_000A);
        tick(3);
        hsk_pulse();
        reg_wr(6'd1, 32'h0003_000A);
        tick(9);
        reg_wr(6'd1, 32'h0001_000A);
        tick(2);
        hsk_pulse();
        reg_rd(6'd5, tmp);
        check("t4_scaler10", tmp, 32'd10);
        check("t4_sat_scaler10", rdat_sat, 32'd10);
        reg_wr(6'd1, 32'h0003_000A);
        reg_wr(6'd1, 32'h0001_000A);
        check("t4_coinc_trig", 32'(trig[1]), 32'h1);
        hsk_pulse();
        reg_rd(6'd5, tmp);
        check("t4_coinc_old", tmp, 32'd0);
        tick(2);
        hsk_pulse();
        reg_rd(6'd5, tmp);
        check("t4_coinc_new", tmp, 32'd1);
        reg_wr(6'd1, 32'h0003_000A);
        tick(19);
        reg_wr(6'd1, 32'h0001_000A);
        tick(2);
        hsk_pulse();
        reg_rd(6'd5, tmp);
        check("t4_scaler20", tmp, 32'd20);
        check("t4_sat15", rdat_sat, 32'd15);

        // register map
        reg_wr(6'd3, 32'h0003_0020);
        reg_rd(6'd3, tmp); check("t5_thresh3", tmp, 32'h0003_0020);
        reg_rd(6'd5, tmp);
        reg_wr(6'd5, 32'h00AB_CDEF);
        reg_rd(6'd5, wdat); check("t5_scaler_ro", wdat, tmp);
        reg_wr(6'd9, 32'hFFFF_FFFF);
        reg_rd(6'd9, tmp); check("t5_unmapped9", tmp, 32'h0);
        reg_rd(6'd63, tmp); check("t5_unmapped63", tmp, 32'h0);
        reg_rd(6'd0, tmp); check("t5_thresh0_kept", tmp, 32'h0001_0064);

        // reset while channel 3 triggers with holdoff counting
        reg_wr(6'd8, 32'd5);
        tick(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_trig", 32'(trig), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_post_trig", 32'(trig), 32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            reg_rd(6'(c), tmp);
            check($sformatf("t6_thresh%0d", c), tmp, 32'h0001_3FFF);
        end
        reg_rd(6'd8, tmp); check("t6_holdoff", tmp, 32'h0);
        reg_rd(6'd5, tmp); check("t6_scaler1", tmp, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
